// File: rtl/ahb_lite_arbiter.sv
// Two-master AHB-Lite arbiter and bus mux in front of a single memory slave.
// Address-phase signals follow the current grant owner; HWDATA, HRESP and
// HREADY follow the data-phase owner. Round-robin arbitration happens only
// when the owner is IDLE, unlocked and the slave is ready, so a transfer or
// burst is never pre-empted.
module ahb_lite_arbiter #(
    parameter int ADDRWIDTH  = 32,
    parameter int DATAWIDTH  = 32,
    parameter int WAIT_LIMIT = 15
) (
    input  logic                 HCLK,
    input  logic                 HRESETn,
    // master 0 slave port
    input  logic [1:0]           M0_HTRANS,
    input  logic [ADDRWIDTH-1:0] M0_HADDR,
    input  logic                 M0_HWRITE,
    input  logic [2:0]           M0_HSIZE,
    input  logic [2:0]           M0_HBURST,
    input  logic [3:0]           M0_HPROT,
    input  logic                 M0_HMASTLOCK,
    input  logic [DATAWIDTH-1:0] M0_HWDATA,
    output logic                 M0_HREADY,
    output logic                 M0_HRESP,
    output logic [DATAWIDTH-1:0] M0_HRDATA,
    output logic                 M0_STARVE,
    // master 1 slave port
    input  logic [1:0]           M1_HTRANS,
    input  logic [ADDRWIDTH-1:0] M1_HADDR,
    input  logic                 M1_HWRITE,
    input  logic [2:0]           M1_HSIZE,
    input  logic [2:0]           M1_HBURST,
    input  logic [3:0]           M1_HPROT,
    input  logic                 M1_HMASTLOCK,
    input  logic [DATAWIDTH-1:0] M1_HWDATA,
    output logic                 M1_HREADY,
    output logic                 M1_HRESP,
    output logic [DATAWIDTH-1:0] M1_HRDATA,
    output logic                 M1_STARVE,
    // memory slave master port
    output logic                 S_HSEL,
    output logic [ADDRWIDTH-1:0] S_HADDR,
    output logic                 S_HWRITE,
    output logic [2:0]           S_HSIZE,
    output logic [2:0]           S_HBURST,
    output logic [3:0]           S_HPROT,
    output logic [1:0]           S_HTRANS,
    output logic                 S_HMASTLOCK,
    output logic [DATAWIDTH-1:0] S_HWDATA,
    output logic                 S_HREADY,
    input  logic                 S_HREADYOUT,
    input  logic                 S_HRESP,
    input  logic [DATAWIDTH-1:0] S_HRDATA
);

    localparam logic [1:0] HT_IDLE   = 2'b00;
    localparam logic [1:0] HT_NONSEQ = 2'b10;
    localparam logic [7:0] LIMIT     = 8'(WAIT_LIMIT);

    logic       grant_q, grant_d;
    logic       last_q, last_d;
    logic       dvalid_q, dvalid_d;
    logic       downer_q, downer_d;
    logic [7:0] wait0_q, wait0_d;
    logic [7:0] wait1_q, wait1_d;

    logic       req0, req1;
    logic [1:0] own_trans;
    logic       own_lock;
    logic       arb_pt;
    logic       m0_dphase, m1_dphase;
    logic       m0_ready, m1_ready;

    // Saturating stall-counter increment.
    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    assign req0      = (M0_HTRANS == HT_NONSEQ);
    assign req1      = (M1_HTRANS == HT_NONSEQ);
    assign own_trans = grant_q ? M1_HTRANS : M0_HTRANS;
    assign own_lock  = grant_q ? M1_HMASTLOCK : M0_HMASTLOCK;
    assign arb_pt    = S_HREADYOUT && (own_trans == HT_IDLE) && !own_lock;
    assign m0_dphase = dvalid_q && !downer_q;
    assign m1_dphase = dvalid_q && downer_q;

    // Address-phase mux: the slave sees only the grant owner's request.
    always_comb begin
        S_HADDR     = grant_q ? M1_HADDR     : M0_HADDR;
        S_HWRITE    = grant_q ? M1_HWRITE    : M0_HWRITE;
        S_HSIZE     = grant_q ? M1_HSIZE     : M0_HSIZE;
        S_HBURST    = grant_q ? M1_HBURST    : M0_HBURST;
        S_HPROT     = grant_q ? M1_HPROT     : M0_HPROT;
        S_HTRANS    = own_trans;
        S_HMASTLOCK = own_lock;
        S_HSEL      = (own_trans != HT_IDLE);
    end

    // Data-phase routing: write data, response and ready follow the data owner;
    // a master that is neither owner nor requesting sees an always-ready bus.
    always_comb begin
        S_HWDATA  = m1_dphase ? M1_HWDATA : M0_HWDATA;
        S_HREADY  = S_HREADYOUT;
        M0_HRDATA = S_HRDATA;
        M1_HRDATA = S_HRDATA;
        M0_HRESP  = m0_dphase ? S_HRESP : 1'b0;
        M1_HRESP  = m1_dphase ? S_HRESP : 1'b0;
        if (m0_dphase || !grant_q) m0_ready = S_HREADYOUT;
        else                       m0_ready = !req0;
        if (m1_dphase || grant_q)  m1_ready = S_HREADYOUT;
        else                       m1_ready = !req1;
        M0_HREADY = m0_ready;
        M1_HREADY = m1_ready;
        M0_STARVE = (wait0_q >= LIMIT);
        M1_STARVE = (wait1_q >= LIMIT);
    end

    // Round-robin grant decision, taken only at a transfer boundary.
    always_comb begin
        grant_d = grant_q;
        last_d  = last_q;
        if (arb_pt) begin
            if (req0 && req1) begin
                grant_d = !last_q;
                last_d  = !last_q;
            end else if (grant_q ? req0 : req1) begin
                grant_d = !grant_q;
                last_d  = !grant_q;
            end
        end
    end

    // Data-phase tracking advances only when the slave completes a phase.
    always_comb begin
        dvalid_d = dvalid_q;
        downer_d = downer_q;
        if (S_HREADYOUT) begin
            dvalid_d = own_trans[1];
            downer_d = grant_q;
        end
    end

    // Stall counters: count while requesting but held off, clear once ready.
    always_comb begin
        wait0_d = wait0_q;
        wait1_d = wait1_q;
        if (m0_ready)  wait0_d = 8'd0;
        else if (req0) wait0_d = sat_inc(wait0_q);
        if (m1_ready)  wait1_d = 8'd0;
        else if (req1) wait1_d = sat_inc(wait1_q);
    end

    // State registers; last resets to 1 so master 0 wins the first tie.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            grant_q  <= 1'b0;
            last_q   <= 1'b1;
            dvalid_q <= 1'b0;
            downer_q <= 1'b0;
            wait0_q  <= 8'd0;
            wait1_q  <= 8'd0;
        end else begin
            grant_q  <= grant_d;
            last_q   <= last_d;
            dvalid_q <= dvalid_d;
            downer_q <= downer_d;
            wait0_q  <= wait0_d;
            wait1_q  <= wait1_d;
        end
    end

endmodule
